ps2_digit_stream_decoder: RTL and testbench

//  Sequential PS/2 set-2 scancode decoder for decimal digits. Consumes a byte stream from the
//  PS/2 receiver and tracks E0 (extended) and F0 (break) prefixes. Maps main-row and optional

---
 rtl/ps2_digit_stream_decoder_pkg.sv | 49 ++++
 rtl/ps2_digit_stream_decoder_if.sv | 23 ++
 rtl/ps2_digit_stream_decoder_fifo.sv | 60 ++++++
 rtl/ps2_digit_stream_decoder.sv | 98 +++++++++
 tb/tb_ps2_digit_stream_decoder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/ps2_digit_stream_decoder_pkg.sv
// Shared scancode constants, FSM state type and digit lookup for the PS/2 digit decoder.
package ps2_digit_stream_decoder_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] digit;
  } lookup_t;

  typedef struct packed {
    logic       rel;
    logic [3:0] digit;
  } event_t;

  function automatic lookup_t digit_lookup(input logic [7:0] code, input logic keypad_en);
    lookup_t r;
    r.hit   = 1'b1;
    r.digit = 4'd0;
    case (code)
      8'h45: r.digit = 4'd0;
      8'h16: r.digit = 4'd1;
      8'h1E: r.digit = 4'd2;
      8'h26: r.digit = 4'd3;
      8'h25: r.digit = 4'd4;
      8'h2E: r.digit = 4'd5;
      8'h36: r.digit = 4'd6;
      8'h3D: r.digit = 4'd7;
      8'h3E: r.digit = 4'd8;
      8'h46: r.digit = 4'd9;
      8'h70: begin r.hit = keypad_en; r.digit = 4'd0; end
      8'h69: begin r.hit = keypad_en; r.digit = 4'd1; end
      8'h72: begin r.hit = keypad_en; r.digit = 4'd2; end
      8'h7A: begin r.hit = keypad_en; r.digit = 4'd3; end
      8'h6B: begin r.hit = keypad_en; r.digit = 4'd4; end
      8'h73: begin r.hit = keypad_en; r.digit = 4'd5; end
      8'h74: begin r.hit = keypad_en; r.digit = 4'd6; end
      8'h6C: begin r.hit = keypad_en; r.digit = 4'd7; end
      8'h75: begin r.hit = keypad_en; r.digit = 4'd8; end
      8'h7D: begin r.hit = keypad_en; r.digit = 4'd9; end
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_digit_stream_decoder_if.sv
// Byte-in / digit-event-out bundle between the PS/2 receiver, the decoder and its consumer.
interface ps2_digit_stream_decoder_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       code_in;
  logic             code_vld;
  logic [3:0]       out_data;
  logic             out_release;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic [CNT_W-1:0] invalid_cnt;

  modport master (
    output code_in, code_vld, out_ready,
    input  out_data, out_release, out_valid, overflow, invalid_cnt
  );

  modport slave (
    input  code_in, code_vld, out_ready,
    output out_data, out_release, out_valid, overflow, invalid_cnt
  );
endinterface

// File: rtl/ps2_digit_stream_decoder_fifo.sv
// Synchronous FIFO with a registered head word; head reads 0 whenever the FIFO is empty.
module ps2_digit_stream_decoder_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full, push_acc, pop_acc;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign pop_acc  = pop_i && (count_q != '0);
  assign push_acc = push_i && (!full || pop_acc);

  always_comb begin
    wr_ptr_d = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_acc  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_acc && !pop_acc) count_d = count_q + (AW+1)'(1);
    if (!push_acc && pop_acc) count_d = count_q - (AW+1)'(1);
    // The next head may be the word being written this very cycle.
    if (count_d == '0)                          head_d = '0;
    else if (push_acc && wr_ptr_q == rd_ptr_d)  head_d = wdata_i;
    else                                        head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = head_q;
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/ps2_digit_stream_decoder.sv
// PS/2 set-2 digit decoder: prefix-tracking FSM, registered decode stage and event FIFO.
module ps2_digit_stream_decoder
  import ps2_digit_stream_decoder_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter bit KEYPAD_EN    = 1'b1,
  parameter bit EMIT_RELEASE = 1'b0,
  parameter int CNT_W        = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  ps2_digit_stream_decoder_if.slave  bus
);
  state_e               state_q, state_d;
  logic                 evt_vld_q, evt_vld_d;
  event_t               evt_q, evt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cnt_inc;
  logic                 ovf_q;
  lookup_t              lk;
  event_t               head;
  logic                 fifo_empty, fifo_pop, drop;
  logic [$clog2(DEPTH):0] fifo_count;

  always_comb begin
    state_d   = state_q;
    evt_vld_d = 1'b0;
    evt_d     = evt_q;
    cnt_inc   = 1'b0;
    lk        = digit_lookup(bus.code_in, KEYPAD_EN);
    if (bus.code_vld) begin
      case (state_q)
        S_IDLE: begin
          if (bus.code_in == SC_EXT)      state_d = S_EXT;
          else if (bus.code_in == SC_BRK) state_d = S_BRK;
          else if (lk.hit) begin
            evt_vld_d = 1'b1;
            evt_d     = '{rel: 1'b0, digit: lk.digit};
          end else cnt_inc = 1'b1;
        end
        S_EXT: state_d = (bus.code_in == SC_BRK) ? S_EXT_BRK : S_IDLE;
        default: begin
          // A prefix after a break prefix is a protocol error; restart from the new prefix.
          if (bus.code_in == SC_EXT) begin
            cnt_inc = 1'b1;
            state_d = S_EXT;
          end else if (bus.code_in == SC_BRK) begin
            cnt_inc = 1'b1;
            state_d = S_BRK;
          end else begin
            state_d = S_IDLE;
            if (state_q == S_BRK && lk.hit && EMIT_RELEASE) begin
              evt_vld_d = 1'b1;
              evt_d     = '{rel: 1'b1, digit: lk.digit};
            end
          end
        end
      endcase
    end
    cnt_d = (cnt_inc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      evt_vld_q <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      evt_vld_q <= evt_vld_d;
      cnt_q     <= cnt_d;
      ovf_q     <= drop;
    end
  end

  always_ff @(posedge clk) evt_q <= evt_d;

  assign fifo_pop = bus.out_ready && !fifo_empty;
  assign drop     = evt_vld_q && (fifo_count == ($clog2(DEPTH)+1)'(DEPTH)) && !fifo_pop;

  ps2_digit_stream_decoder_fifo #(.WIDTH(5), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (evt_vld_q),
    .wdata_i (evt_q),
    .pop_i   (bus.out_ready),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.out_data    = head.digit;
  assign bus.out_release = head.rel;
  assign bus.out_valid   = !fifo_empty;
  assign bus.overflow    = ovf_q;
  assign bus.invalid_cnt = cnt_q;
endmodule

// File: tb/tb_ps2_digit_stream_decoder.sv
// Directed bench: a default-parameter decoder and an EMIT_RELEASE=1 decoder fed the same bytes.
module tb_ps2_digit_stream_decoder;
  logic clk = 1'b0;
  logic resetn;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  ps2_digit_stream_decoder_if #(.CNT_W(8)) bus0 ();
  ps2_digit_stream_decoder_if #(.CNT_W(8)) bus1 ();

  ps2_digit_stream_decoder #(.DEPTH(4), .KEYPAD_EN(1'b1), .EMIT_RELEASE(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0.slave)
  );
  ps2_digit_stream_decoder #(.DEPTH(4), .KEYPAD_EN(1'b1), .EMIT_RELEASE(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1.slave)
  );

  typedef struct {
    logic [7:0] code;
    logic       vld;
    logic       ev;
    logic [3:0] ed;
    logic [7:0] ecnt;
  } vec_t;

  vec_t       vt [44];
  logic [7:0] digs [20];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step(input logic [7:0] c, input logic v);
    bus0.code_in = c; bus0.code_vld = v;
    bus1.code_in = c; bus1.code_vld = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(8'h00, 1'b0);
    resetn = 1'b1;
  endtask

  // {valid, data, release, overflow, cnt} of dut0, with data/release masked when not valid
  function automatic logic [31:0] obs0();
    return {17'd0, bus0.out_valid, bus0.out_valid ? bus0.out_data : 4'd0,
            bus0.out_valid & bus0.out_release, bus0.overflow, bus0.invalid_cnt};
  endfunction

  function automatic logic [31:0] exp0(input logic v, input logic [3:0] d, input logic r,
                                       input logic o, input logic [7:0] c);
    return {17'd0, v, v ? d : 4'd0, v & r, o, c};
  endfunction

  initial begin
    resetn = 1'b0;
    set_ready(1'b1);
    bus0.code_in = 8'h00; bus0.code_vld = 1'b0;
    bus1.code_in = 8'h00; bus1.code_vld = 1'b0;

    digs = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
             8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    vt[0]  = '{8'h16, 1'b1, 1'b0, 4'd0, 8'd0};
    vt[1]  = '{8'hF0, 1'b1, 1'b1, 4'd1, 8'd0};
    vt[2]  = '{8'h16, 1'b1, 1'b0, 4'd0, 8'd0};
    vt[3]  = '{8'h00, 1'b0, 1'b0, 4'd0, 8'd0};
    vt[4]  = '{8'hE0, 1'b1, 1'b0, 4'd0, 8'd0};
    vt[5]  = '{8'h70, 1'b1, 1'b0, 4'd0, 8'd0};
    vt[6]  = '{8'h70, 1'b1, 1'b0, 4'd0, 8'd0};
    vt[7]  = '{8'h00, 1'b0, 1'b1, 4'd0, 8'd0};
    vt[8]  = '{8'h00, 1'b0, 1'b0, 4'd0, 8'd0};
    vt[9]  = '{8'h1C, 1'b1, 1'b0, 4'd0, 8'd1};
    vt[10] = '{8'hF0, 1'b1, 1'b0, 4'd0, 8'd1};
    vt[11] = '{8'hF0, 1'b1, 1'b0, 4'd0, 8'd2};
    vt[12] = '{8'h1C, 1'b1, 1'b0, 4'd0, 8'd2};
    vt[13] = '{8'hE0, 1'b1, 1'b0, 4'd0, 8'd2};
    vt[14] = '{8'hF0, 1'b1, 1'b0, 4'd0, 8'd2};
    vt[15] = '{8'h70, 1'b1, 1'b0, 4'd0, 8'd2};
    vt[16] = '{8'hE0, 1'b1, 1'b0, 4'd0, 8'd2};
    vt[17] = '{8'hE0, 1'b1, 1'b0, 4'd0, 8'd2};
    for (int k = 0; k < 20; k++)
      vt[18+k] = '{digs[k], 1'b1, (k > 0), 4'((k + 9) % 10), 8'd2};
    vt[38] = '{8'h00, 1'b0, 1'b1, 4'd9, 8'd2};
    vt[39] = '{8'h00, 1'b0, 1'b0, 4'd0, 8'd2};
    vt[40] = '{8'hF0, 1'b1, 1'b0, 4'd0, 8'd2};
    vt[41] = '{8'hE0, 1'b1, 1'b0, 4'd0, 8'd3};
    vt[42] = '{8'h16, 1'b1, 1'b0, 4'd0, 8'd3};
    vt[43] = '{8'h00, 1'b0, 1'b0, 4'd0, 8'd3};

    do_reset();
    chk("reset_state", obs0(), exp0(1'b0, 4'd0, 1'b0, 1'b0, 8'd0));
    chk("reset_data", {27'd0, bus0.out_release, bus0.out_data}, 32'd0);

    for (int i = 0; i < 44; i++) begin
      step(vt[i].code, vt[i].vld);
      chk($sformatf("vec%0d", i), obs0(), exp0(vt[i].ev, vt[i].ed, 1'b0, 1'b0, vt[i].ecnt));
    end

    // Release events in order on the EMIT_RELEASE=1 instance
    do_reset();
    step(8'h3E, 1'b1);
    step(8'hF0, 1'b1);
    chk("rel_make", {29'd0, bus1.out_valid, bus1.out_release, bus1.out_data == 4'd8}, 32'b111 & 32'b101);
    step(8'h3E, 1'b1);
    chk("rel_gap", {31'd0, bus1.out_valid}, 32'd0);
    step(8'h00, 1'b0);
    chk("rel_break", {27'd0, bus1.out_valid, bus1.out_release, bus1.out_data}, {27'd0, 1'b1, 1'b1, 4'd8});
    chk("norel_dut0", {31'd0, bus0.out_valid}, 32'd0);

    // Overflow: DEPTH+1 makes with consumer stalled
    do_reset();
    set_ready(1'b0);
    step(8'h16, 1'b1); step(8'h1E, 1'b1); step(8'h26, 1'b1); step(8'h25, 1'b1); step(8'h2E, 1'b1);
    chk("full_no_ovf", obs0(), exp0(1'b1, 4'd1, 1'b0, 1'b0, 8'd0));
    step(8'h00, 1'b0);
    chk("ovf_pulse", obs0(), exp0(1'b1, 4'd1, 1'b0, 1'b1, 8'd0));
    step(8'h00, 1'b0);
    chk("ovf_clear", obs0(), exp0(1'b1, 4'd1, 1'b0, 1'b0, 8'd0));
    set_ready(1'b1);
    for (int k = 2; k <= 4; k++) begin
      step(8'h00, 1'b0);
      chk($sformatf("drain%0d", k), obs0(), exp0(1'b1, 4'(k), 1'b0, 1'b0, 8'd0));
    end
    step(8'h00, 1'b0);
    chk("drain_empty", obs0(), exp0(1'b0, 4'd0, 1'b0, 1'b0, 8'd0));

    // Full with simultaneous push and pop
    set_ready(1'b0);
    step(8'h16, 1'b1); step(8'h1E, 1'b1); step(8'h26, 1'b1); step(8'h25, 1'b1); step(8'h2E, 1'b1);
    set_ready(1'b1);
    for (int k = 2; k <= 5; k++) begin
      step(8'h00, 1'b0);
      chk($sformatf("pushpop%0d", k), obs0(), exp0(1'b1, 4'(k), 1'b0, 1'b0, 8'd0));
    end
    step(8'h00, 1'b0);
    chk("pushpop_empty", obs0(), exp0(1'b0, 4'd0, 1'b0, 1'b0, 8'd0));

    // Invalid counter saturation
    do_reset();
    for (int k = 0; k < 254; k++) step(8'h1C, 1'b1);
    chk("cnt_254", {24'd0, bus0.invalid_cnt}, 32'hFE);
    for (int k = 0; k < 10; k++) step(8'h1C, 1'b1);
    chk("cnt_sat", {24'd0, bus0.invalid_cnt}, 32'hFF);

    // Reset mid-sequence clears queue and pending prefix
    do_reset();
    set_ready(1'b0);
    step(8'h16, 1'b1);
    step(8'h00, 1'b0);
    chk("queued", obs0(), exp0(1'b1, 4'd1, 1'b0, 1'b0, 8'd0));
    step(8'hE0, 1'b1);
    do_reset();
    chk("midreset", obs0(), exp0(1'b0, 4'd0, 1'b0, 1'b0, 8'd0));
    set_ready(1'b1);
    step(8'h45, 1'b1);
    chk("post_rst_lat", obs0(), exp0(1'b0, 4'd0, 1'b0, 1'b0, 8'd0));
    step(8'h00, 1'b0);
    chk("post_rst_evt", obs0(), exp0(1'b1, 4'd0, 1'b0, 1'b0, 8'd0));
    step(8'h00, 1'b0);
    chk("post_rst_empty", obs0(), exp0(1'b0, 4'd0, 1'b0, 1'b0, 8'd0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
